// File: rtl/shift_seq.sv
// shift_seq: four-stage sequential shifter/rotator applying one 2^k step per cycle
module shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] in,
    input  logic [3:0]  cnt,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [1:0]  k;
    logic [1:0]  op_q;
    logic [3:0]  cnt_q;
    logic [15:0] w;
    logic [3:0]  amt;
    logic [31:0] dbl_l;
    logic [31:0] dbl_r;
    logic [15:0] sh;
    logic [15:0] nxt;
    always_comb begin
        amt   = 4'd1 << k;
        dbl_l = {w, w} << amt;
        dbl_r = {w, w} >> amt;
        sh    = op_q == 2'b00 ? dbl_l[31:16] :
                op_q == 2'b01 ? w << amt :
                op_q == 2'b10 ? dbl_r[15:0] :
                                16'($signed(w) >>> amt);
        nxt   = cnt_q[k] ? sh : w;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            k     <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            w     <= '0;
        end else begin
            case (state)
                RUN: begin
                    w <= nxt;
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= DONE;
                        out   <= nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        op_q  <= op;
                        cnt_q <= cnt;
                        w     <= in;
                        k     <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed checks of shift_seq results, timing, ignore and abort behaviour
module tb_shift_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  op;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [15:0] out;
    logic        busy, done;
    int          total = 0;
    int          passed = 0;
    logic [15:0] last_exp = 16'h0000;

    shift_seq dut (.clk(clk), .rst(rst), .start(start), .op(op), .in(in), .cnt(cnt),
                   .out(out), .busy(busy), .done(done));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    // Accept at the next edge, then expect 4 busy cycles and done in the 5th.
    task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] d,
                          input logic [3:0] c, input logic [15:0] exp, input bit poke);
        start = 1'b1; op = o; in = d; cnt = c;
        tick();
        start = 1'b0; in = ~d; cnt = ~c; op = ~o;
        for (int i = 0; i < 4; i++) begin
            chk({name, "_busy"}, {15'b0, busy}, 16'h0001);
            chk({name, "_nodone"}, {15'b0, done}, 16'h0000);
            chk({name, "_hold"}, out, last_exp);
            if (poke && i == 1) begin
                start = 1'b1; in = 16'hFFFF; op = 2'b10; cnt = 4'd7;
            end
            tick();
            start = 1'b0;
        end
        chk({name, "_done"}, {15'b0, done}, 16'h0001);
        chk({name, "_idle"}, {15'b0, busy}, 16'h0000);
        chk({name, "_out"}, out, exp);
        last_exp = exp;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 2'b01; in = 16'hABCD; cnt = 4'd3;
        tick();
        tick();
        chk("rst_out", out, 16'h0000);
        chk("rst_busy", {15'b0, busy}, 16'h0000);
        chk("rst_done", {15'b0, done}, 16'h0000);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("post_rst_idle", {15'b0, busy}, 16'h0000);

        run_op("sll", 2'b01, 16'h00F1, 4'd4, 16'h0F10, 1'b0);
        tick();
        chk("pulse_once", {15'b0, done}, 16'h0000);
        chk("out_holds", out, 16'h0F10);
        run_op("rol", 2'b00, 16'h8001, 4'd1, 16'h0003, 1'b0);
        run_op("ror", 2'b10, 16'h0001, 4'd1, 16'h8000, 1'b0);
        run_op("sra_neg", 2'b11, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        run_op("sra_pos", 2'b11, 16'h4000, 4'd15, 16'h0000, 1'b0);
        run_op("ror_mix", 2'b10, 16'h1234, 4'd5, 16'hA091, 1'b0);
        run_op("rol_mix", 2'b00, 16'h1234, 4'd12, 16'h4123, 1'b0);
        tick();
        run_op("cnt0", 2'b01, 16'h1234, 4'd0, 16'h1234, 1'b0);
        run_op("b2b", 2'b01, 16'h0001, 4'd15, 16'h8000, 1'b0);
        tick();
        run_op("ignore", 2'b01, 16'h0003, 4'd1, 16'h0006, 1'b1);
        tick();
        chk("not_queued", {15'b0, busy}, 16'h0000);

        start = 1'b1; op = 2'b00; in = 16'h00FF; cnt = 4'd15;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out", out, 16'h0000);
        chk("abort_busy", {15'b0, busy}, 16'h0000);
        chk("abort_done", {15'b0, done}, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_nodone", {15'b0, done}, 16'h0000);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
